// File: rtl/addsub_serial.sv
// addsub_serial: multi-cycle adder/subtractor that adds CHUNK bits per clock.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   in_valid/ready  operand handshake; in_ready is high only while idle
//   a, b, sub       operands; sub=1 selects a-b, sub=0 selects a+b
//   out_valid/ready result handshake; out_valid is high only in DONE
//   result          WIDTH-bit sum or difference
//   cout            unsigned carry (add) or unsigned borrow (sub, a<b)
//   ovf             two's-complement signed overflow
//
// Parameters: WIDTH (operand width), CHUNK (bits per cycle, divides WIDTH).
// Optional macro ADDSUB_SAT_EN: saturate result to signed max/min on overflow.
// cout and ovf always report the unsaturated condition.

module addsub_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned MSB    = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;        // b already inverted for subtraction
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic             sub_r;
  logic [CW-1:0]    cnt;

  logic             last;
  int unsigned      base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] sum_full;
  logic [WIDTH-1:0] result_nxt;
  logic             cout_nxt;
  logic             ovf_nxt;

  assign in_ready = (state == IDLE);
  assign last     = (cnt == CW'(NCHUNK - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One chunk of the ripple add, plus the final-cycle flag/result computation
  always_comb begin
    base      = 32'(cnt) * CHUNK;
    a_chunk   = a_r[base +: CHUNK];
    b_chunk   = b_r[base +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    sum_full  = sum_r;
    sum_full[base +: CHUNK] = chunk_sum[CHUNK-1:0];
    // Carry-out of an inverted-b add is the complement of the borrow.
    cout_nxt  = sub_r ^ chunk_sum[CHUNK];
    ovf_nxt   = (a_r[MSB] == b_r[MSB]) && (sum_full[MSB] != a_r[MSB]);
    result_nxt = sum_full;
`ifdef ADDSUB_SAT_EN
    if (ovf_nxt) begin
      result_nxt      = {WIDTH{~a_r[MSB]}};
      result_nxt[MSB] = a_r[MSB];
    end
`endif
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      sum_r     <= '0;
      carry     <= 1'b0;
      sub_r     <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b ^ {WIDTH{sub}};
            carry <= sub;
            sub_r <= sub;
            cnt   <= '0;
            sum_r <= '0;
          end
        end
        RUN: begin
          sum_r <= sum_full;
          carry <= chunk_sum[CHUNK];
          cnt   <= cnt + CW'(1);
          if (last) begin
            result    <= result_nxt;
            cout      <= cout_nxt;
            ovf       <= ovf_nxt;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: directed self-checking bench for addsub_serial.
// Covers a 16/4 instance and an 8/8 single-chunk instance.

module tb_addsub_serial;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
  logic        ovf;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        sub8;
  logic        out_valid8;
  logic        out_ready8;
  logic [7:0]  result8;
  logic        cout8;
  logic        ovf8;

  int checks = 0;
  int errors = 0;

  addsub_serial #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf)
  );

  addsub_serial #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .cout(cout8), .ovf(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation, measure latency, check outputs, complete the handshake.
  // hold > 0: keep out_ready low for that many DONE cycles while pulsing in_valid.
  task automatic do_op(input logic [15:0] oa, input logic [15:0] ob, input logic os,
                       input logic [15:0] er, input logic ec, input logic eo,
                       input logic early, input int hold, input string tag);
    int lat;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = oa; b = ob; sub = os; in_valid = 1'b1; out_ready = early;
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        a = 16'h1111; b = 16'h2222; sub = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_hold_result"}, 32'(result), 32'(er));
        check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_done_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat8;
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; out_ready8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic add, accepted on the first edge after reset release
    do_op(16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0, 0, "add5_3");
    do_op(16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0, 0, "sub3_5");
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0, "addFFFF_1");
`ifdef ADDSUB_SAT_EN
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 0, "ovf_pos");
    do_op(16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 0, "ovf_neg");
`else
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0, "ovf_pos");
    do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 0, "ovf_neg");
`endif
    do_op(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 0, "sub_eq");
    do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 3, "hold");
    // The pulses during hold must not have started an operation
    @(posedge clk); #1;
    check("post_hold_out_valid", 32'(out_valid), 32'd0);
    check("post_hold_in_ready", 32'(in_ready), 32'd1);

    // Abort in the 2nd RUN cycle
    a = 16'h7000; b = 16'h7000; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 0, "after_abort");

    // Single-chunk instance: result one edge after accept
    a8 = 8'h80; b8 = 8'h80; sub8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    check("w8_pre_valid", 32'(out_valid8), 32'd0);
    lat8 = 0;
    while (!out_valid8 && lat8 < 20) begin
      @(posedge clk); #1;
      lat8++;
    end
    check("w8_latency", 32'(lat8), 32'd1);
`ifdef ADDSUB_SAT_EN
    check("w8_result", 32'(result8), 32'h80);
`else
    check("w8_result", 32'(result8), 32'h00);
`endif
    check("w8_cout", 32'(cout8), 32'd1);
    check("w8_ovf", 32'(ovf8), 32'd1);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check("w8_done_in_ready", 32'(in_ready8), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, giving the bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, with CHUNK >= 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand set is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port sub, input, 1 bit: 1 selects a-b, 0 selects a+b.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is available.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port result, output, WIDTH bits: the sum or difference.
REQ-012 The block SHALL have port cout, output, 1 bit: unsigned carry for add, or unsigned borrow for sub (set when a<b).
REQ-013 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 An operand set SHALL be accepted on a rising edge with in_valid=1 in IDLE: capture a and b^{WIDTH{sub}}, set the carry to sub, clear the chunk counter, and go to RUN.
REQ-016 Each RUN cycle SHALL add the least-significant unprocessed CHUNK bits with the carry, store the CHUNK-bit sum, and propagate the chunk carry-out to the next cycle.
REQ-017 RUN SHALL last exactly WIDTH/CHUNK cycles, so out_valid rises WIDTH/CHUNK clock edges after the accept edge (1 edge when CHUNK=WIDTH).
REQ-018 On entry to DONE: cout = sub XOR final carry; ovf = (a[MSB]==b'[MSB]) AND (sum[MSB]!=a[MSB]), where b' is the inverted b when sub=1.
REQ-019 In DONE, result, cout and ovf SHALL hold stable until out_valid and out_ready are both 1 on an edge, after which the state SHALL return to IDLE.
REQ-020 If out_ready is already 1 when DONE is entered, the handshake SHALL complete on the first DONE edge (one cycle of out_valid).
REQ-021 in_valid, a, b and sub SHALL be ignored in RUN and DONE; accepting new operands in the same cycle as the output handshake SHALL NOT occur.
REQ-022 The minimum issue interval SHALL be WIDTH/CHUNK+2 cycles.
REQ-023 result, cout, ovf and out_valid SHALL be driven from registers; in_ready SHALL be a decode of the state.

Reset
REQ-024 While rst_n=0, the state SHALL be IDLE, result/cout/ovf/out_valid SHALL be 0, all internal registers SHALL be 0, and in_ready SHALL be 1.
REQ-025 rst_n asserted in RUN or DONE SHALL immediately abort the operation with no output handshake, and the aborted result SHALL never appear.
REQ-026 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-027 With ADDSUB_SAT_EN defined, when ovf=1 the result SHALL saturate to the signed maximum (0111..1) if a[MSB]=0, or to the signed minimum (1000..0) if a[MSB]=1; ovf and cout SHALL still report the unsaturated condition.
REQ-028 Without ADDSUB_SAT_EN, the result SHALL be the wrapped WIDTH-bit value and SHALL contain no saturation logic.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-029 Accept a=0x0005, b=0x0003, sub=0 -> out_valid 4 edges later; result=0x0008, cout=0, ovf=0.
REQ-030 a=0x0003, b=0x0005, sub=1 -> result=0xFFFE, cout=1, ovf=0; then a=0xFFFF, b=0x0001, sub=0 -> result=0x0000, cout=1, ovf=0.
REQ-031 a=0x7FFF, b=0x0001, sub=0 -> ovf=1, cout=0, result=0x8000 (0x7FFF with ADDSUB_SAT_EN); a=0x8000, b=0x0001, sub=1 -> ovf=1, cout=0, result=0x7FFF (0x8000 with ADDSUB_SAT_EN).
REQ-032 Hold out_ready=0 for 3 cycles in DONE while pulsing in_valid with new operands -> result stable, in_ready=0, pulses ignored; out_ready=1 -> IDLE on the next edge.
REQ-033 Assert rst_n=0 in the 2nd RUN cycle -> all outputs 0 and in_ready=1 immediately; after release, a new add of 1+1 yields 0x0002 with no stale data.
REQ-034 With WIDTH=8, CHUNK=8: a=0x80, b=0x80, sub=0 -> out_valid 1 edge after accept; result=0x00, cout=1, ovf=1.
